// File: rtl/csr_types_pkg.sv
// Shared CSR-side types and register-map constants for the machine timer/interrupt unit.
package csr_types_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned MTIME_W  = 64;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned PRESC_W  = 16;

    // Word offsets of the timer registers on the register bus
    localparam logic [ADDR_W-1:0] MSIP_OFFSET        = 3'd0;
    localparam logic [ADDR_W-1:0] MTIMECMP_LO_OFFSET = 3'd2;
    localparam logic [ADDR_W-1:0] MTIMECMP_HI_OFFSET = 3'd3;
    localparam logic [ADDR_W-1:0] MTIME_LO_OFFSET    = 3'd4;
    localparam logic [ADDR_W-1:0] MTIME_HI_OFFSET    = 3'd5;

    // Machine interrupt-pending register layout
    typedef struct packed {
        logic [19:0] rsvd_hi;  // 31:12
        logic        meip;     // 11
        logic        rsvd10;
        logic        seip;     // 9
        logic        rsvd8;
        logic        mtip;     // 7
        logic        rsvd6;
        logic        stip;     // 5
        logic        rsvd4;
        logic        msip;     // 3
        logic        rsvd2;
        logic        ssip;     // 1
        logic        rsvd0;
    } mip_t;

endpackage

// File: rtl/machine_timer_irq_sync.sv
// Two-flop synchroniser for asynchronous interrupt levels.
module irq_synchronizer #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Next-state: shift the async level through two stages
    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
    end

    // Synchroniser flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/machine_timer_irq.sv
// Machine timer (mtime/mtimecmp), software interrupt bit and external-interrupt
// synchronisation, producing the hardware-driven mip bits.
module machine_timer_irq
    import csr_types_pkg::*;
#(
    parameter int unsigned        TICK_DIV       = 1,
    parameter logic [MTIME_W-1:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              ack,
    output logic [XLEN-1:0]   rdata,
    input  logic              ext_irq_async,
    output mip_t              mip_hw
);

    localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [MTIME_W-1:0] mtime_q, mtime_d;
    logic [MTIME_W-1:0] mtimecmp_q, mtimecmp_d;
    logic               msip_q, msip_d;
    logic               mtip_q, mtip_d;
    logic               ack_q, ack_d;
    logic [XLEN-1:0]    rdata_q, rdata_d;
    logic               meip_sync;

    logic               tick;
    logic               wr_en;
    logic               mtime_wr;
    logic [XLEN-1:0]    rd_val;

    // External interrupt level into the clk domain
    irq_synchronizer #(
        .WIDTH (1)
    ) u_meip_sync (
        .clk     (clk),
        .rst_n   (rst),
        .async_i (ext_irq_async),
        .sync_o  (meip_sync)
    );

    // Register read mux, sampled from current register values
    always_comb begin
        rd_val = '0;
        case (addr)
            MSIP_OFFSET:        rd_val = {31'b0, msip_q};
            MTIMECMP_LO_OFFSET: rd_val = mtimecmp_q[31:0];
            MTIMECMP_HI_OFFSET: rd_val = mtimecmp_q[63:32];
            MTIME_LO_OFFSET:    rd_val = mtime_q[31:0];
            MTIME_HI_OFFSET:    rd_val = mtime_q[63:32];
            default:            rd_val = '0;
        endcase
    end

    // Next-state: prescaler, mtime, mtimecmp, msip, bus response and compare
    always_comb begin
        tick       = (presc_q == TICK_LAST);
        wr_en      = req & wr;
        presc_d    = tick ? '0 : presc_q + PRESC_W'(1);
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        mtime_wr   = 1'b0;

        if (wr_en) begin
            case (addr)
                MSIP_OFFSET:        msip_d            = wdata[0];
                MTIMECMP_LO_OFFSET: mtimecmp_d[31:0]  = wdata;
                MTIMECMP_HI_OFFSET: mtimecmp_d[63:32] = wdata;
                MTIME_LO_OFFSET: begin
                    mtime_d[31:0] = wdata;
                    mtime_wr      = 1'b1;
                end
                MTIME_HI_OFFSET: begin
                    mtime_d[63:32] = wdata;
                    mtime_wr       = 1'b1;
                end
                default: ;
            endcase
        end

        // A software write to mtime wins over the tick; full 64-bit add keeps the carry coherent
        if (!mtime_wr && tick) begin
            mtime_d = mtime_q + MTIME_W'(1);
        end

        ack_d   = req;
        rdata_d = (req && !wr) ? rd_val : '0;
        mtip_d  = (mtime_q >= mtimecmp_q);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RESET;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
        end
    end

    // Pending-bit assembly from registered sources only
    always_comb begin
        mip_hw      = '0;
        mip_hw.meip = meip_sync;
        mip_hw.mtip = mtip_q;
        mip_hw.msip = msip_q;
    end

    assign ack   = ack_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_machine_timer_irq.sv
// Randomised and directed bench for machine_timer_irq, run on TICK_DIV=1 and TICK_DIV=4 copies.
module tb_machine_timer_irq;
    import csr_types_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        ext;

    logic        ack1, ack4;
    logic [31:0] rdata1, rdata4;
    mip_t        mip1, mip4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    machine_timer_irq #(.TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .ack(ack1), .rdata(rdata1), .ext_irq_async(ext), .mip_hw(mip1)
    );

    machine_timer_irq #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .ack(ack4), .rdata(rdata4), .ext_irq_async(ext), .mip_hw(mip4)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: architectural registers as plain integers, one set per divider
    longint unsigned m_mtime[2];
    longint unsigned m_cmp[2];
    int unsigned     m_pres[2];
    bit              m_msip[2];
    bit              e_ack[2];
    logic [31:0]     e_rdata[2];
    bit              e_mtip[2];
    bit              m_ext_last;
    bit              e_meip;

    function automatic int unsigned div_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] model_read(input int i, input logic [2:0] a);
        longint unsigned t, c;
        t = m_mtime[i];
        c = m_cmp[i];
        case (a)
            3'd0:    return {31'b0, m_msip[i]};
            3'd2:    return 32'(c % 64'h1_0000_0000);
            3'd3:    return 32'(c / 64'h1_0000_0000);
            3'd4:    return 32'(t % 64'h1_0000_0000);
            3'd5:    return 32'(t / 64'h1_0000_0000);
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_step();
        bit              tick;
        bit              mtime_written;
        longint unsigned hi, lo;
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_mtime[i] = 0;
                m_cmp[i]   = 64'hFFFF_FFFF_FFFF_FFFF;
                m_pres[i]  = 0;
                m_msip[i]  = 1'b0;
                e_ack[i]   = 1'b0;
                e_rdata[i] = 32'h0;
                e_mtip[i]  = 1'b0;
            end else begin
                e_ack[i]   = req;
                e_rdata[i] = (req && !wr) ? model_read(i, addr) : 32'h0;
                e_mtip[i]  = (m_mtime[i] >= m_cmp[i]);
                tick       = (m_pres[i] == div_of(i) - 1);
                m_pres[i]  = (m_pres[i] + 1) % div_of(i);
                mtime_written = 1'b0;
                if (req && wr) begin
                    case (addr)
                        3'd0: m_msip[i] = wdata[0];
                        3'd2: m_cmp[i] = (m_cmp[i] / 64'h1_0000_0000) * 64'h1_0000_0000 + 64'(wdata);
                        3'd3: m_cmp[i] = (64'(wdata) * 64'h1_0000_0000) + (m_cmp[i] % 64'h1_0000_0000);
                        3'd4: begin
                            hi = m_mtime[i] / 64'h1_0000_0000;
                            m_mtime[i] = hi * 64'h1_0000_0000 + 64'(wdata);
                            mtime_written = 1'b1;
                        end
                        3'd5: begin
                            lo = m_mtime[i] % 64'h1_0000_0000;
                            m_mtime[i] = 64'(wdata) * 64'h1_0000_0000 + lo;
                            mtime_written = 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (!mtime_written && tick) m_mtime[i] = m_mtime[i] + 1;
            end
        end
        // meip shows the external level seen at the previous edge
        if (!rst) begin
            e_meip     = 1'b0;
            m_ext_last = 1'b0;
        end else begin
            e_meip     = m_ext_last;
            m_ext_last = ext;
        end
    endtask

    task automatic compare_all();
        logic [31:0] exp_mip;
        for (int i = 0; i < 2; i++) begin
            exp_mip     = 32'h0;
            exp_mip[11] = e_meip;
            exp_mip[7]  = e_mtip[i];
            exp_mip[3]  = m_msip[i];
            if (i == 0) begin
                check32("d1.ack",   {31'b0, ack1}, {31'b0, e_ack[0]});
                check32("d1.rdata", rdata1, e_rdata[0]);
                check32("d1.mip",   32'(mip1), exp_mip);
            end else begin
                check32("d4.ack",   {31'b0, ack4}, {31'b0, e_ack[1]});
                check32("d4.rdata", rdata4, e_rdata[1]);
                check32("d4.mip",   32'(mip4), exp_mip);
            end
        end
    endtask

    task automatic do_cycle(input logic r, input logic w, input logic [2:0] a, input logic [31:0] d);
        req   = r;
        wr    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) do_cycle(1'b0, 1'b0, 3'd0, 32'h0);
    endtask

    initial begin
        logic [2:0]  ra;
        logic [31:0] rd;
        logic        rr, rw;
        int          guard;

        rst = 1'b0; req = 1'b0; wr = 1'b0; addr = 3'd0; wdata = 32'h0; ext = 1'b0;

        // Reset state
        idle(2);
        check32("rst_ack", {31'b0, ack1}, 32'h0);
        check32("rst_mip", 32'(mip1), 32'h0);
        rst = 1'b1;

        // Idle count and reset compare value
        idle(10);
        do_cycle(1'b1, 1'b0, 3'd4, 32'h0);
        check32("idle_mtime_lo", rdata1, 32'd10);
        check32("idle_mip", 32'(mip1), 32'h0);
        do_cycle(1'b1, 1'b0, 3'd2, 32'h0);
        check32("cmp_lo_rst", rdata1, 32'hFFFF_FFFF);
        do_cycle(1'b1, 1'b0, 3'd3, 32'h0);
        check32("cmp_hi_rst", rdata1, 32'hFFFF_FFFF);

        // mtip rise at mtime==20, then fall after raising mtimecmp
        do_cycle(1'b1, 1'b1, 3'd3, 32'h0);
        do_cycle(1'b1, 1'b1, 3'd2, 32'd20);
        idle(12);
        check32("mtip_up", {31'b0, mip1.mtip}, 32'h1);
        do_cycle(1'b1, 1'b1, 3'd2, 32'hFFFF_FFFF);
        idle(2);
        check32("mtip_down", {31'b0, mip1.mtip}, 32'h0);

        // Carry across the half-word boundary
        do_cycle(1'b1, 1'b1, 3'd5, 32'h0);
        do_cycle(1'b1, 1'b1, 3'd4, 32'hFFFF_FFFE);
        idle(3);
        do_cycle(1'b1, 1'b0, 3'd4, 32'h0);
        check32("carry_lo", rdata1, 32'h1);
        do_cycle(1'b1, 1'b0, 3'd5, 32'h0);
        check32("carry_hi", rdata1, 32'h1);

        // Divided tick: write on a tick cycle, then back-to-back reads
        guard = 0;
        while (m_pres[1] != 3 && guard < 8) begin
            idle(1);
            guard++;
        end
        check32("tick_align", 32'(m_pres[1]), 32'd3);
        do_cycle(1'b1, 1'b1, 3'd4, 32'h0000_1234);
        for (int k = 1; k <= 6; k++) begin
            do_cycle(1'b1, 1'b0, 3'd4, 32'h0);
            check32("div4_ack", {31'b0, ack4}, 32'h1);
            check32("div4_lo", rdata4, (k <= 4) ? 32'h0000_1234 : 32'h0000_1235);
        end

        // msip, meip and unmapped access
        do_cycle(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF);
        check32("msip_bit", {31'b0, mip1.msip}, 32'h1);
        do_cycle(1'b1, 1'b0, 3'd0, 32'h0);
        check32("msip_rd", rdata1, 32'h1);
        ext = 1'b1;
        idle(2);
        check32("meip_up", {31'b0, mip1.meip}, 32'h1);
        ext = 1'b0;
        idle(3);
        check32("meip_down", {31'b0, mip1.meip}, 32'h0);
        do_cycle(1'b1, 1'b1, 3'd7, 32'hDEAD_BEEF);
        do_cycle(1'b1, 1'b0, 3'd7, 32'h0);
        check32("unmapped_ack", {31'b0, ack1}, 32'h1);
        check32("unmapped_rd", rdata1, 32'h0);

        // Reset while a write is in flight
        req = 1'b1; wr = 1'b1; addr = 3'd2; wdata = 32'h5;
        #2 rst = 1'b0;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        check32("midrst_ack", {31'b0, ack1}, 32'h0);
        check32("midrst_mip", 32'(mip1), 32'h0);
        rst = 1'b1;
        do_cycle(1'b1, 1'b0, 3'd2, 32'h0);
        check32("midrst_cmp_lo", rdata1, 32'hFFFF_FFFF);
        do_cycle(1'b1, 1'b0, 3'd4, 32'h0);
        check32("midrst_mtime", rdata1, 32'h1);

        // Random traffic against the model
        for (int n = 0; n < 500; n++) begin
            rr = ($urandom_range(0, 9) < 7);
            rw = $urandom_range(0, 1) == 1;
            ra = 3'($urandom_range(0, 7));
            case (ra)
                3'd2:    rd = 32'(m_mtime[0] % 64'h1_0000_0000) + 32'($urandom_range(0, 40)) - 32'd20;
                3'd3,
                3'd5:    rd = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0;
                default: rd = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ext = ~ext;
            do_cycle(rr, rw, ra, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/machine_timer_irq.md
Name: machine_timer_irq

Overview:
- Machine-level interrupt source unit that sits directly upstream of the CSR unit and produces the hardware-driven mip bits (mtip, msip, meip).
- Holds a 64-bit free-running mtime counter, a 64-bit mtimecmp compare register and an msip software-interrupt bit, all on a 32-bit word-addressed register bus.
- Synchronises the asynchronous external interrupt line into meip.

Parameters:
- TICK_DIV, 1, clk cycles per mtime increment; legal range 1..65535.
- MTIMECMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, mtimecmp value after reset.

Ports:
- clk  input  1  core clock
- rst  input  1  reset; asynchronous assert, active-low (0 = reset), synchronous release by the integrator
- req  input  1  register access request, single-cycle pulse per access
- wr  input  1  1 = write, 0 = read; qualified by req
- addr  input  3  word offset: 0 msip, 2 mtimecmp_lo, 3 mtimecmp_hi, 4 mtime_lo, 5 mtime_hi; 1/6/7 unmapped
- wdata  input  32  write data
- ack  output  1  access complete, one cycle after req
- rdata  output  32  read data; valid only while ack=1, otherwise 0
- ext_irq_async  input  1  external interrupt level, asynchronous to clk
- mip_hw  output  32  mip_t-formatted pending bits; only meip, mtip and msip are driven, all other bits 0

Behaviour:
- Reset values:
  - mtime = 0; prescaler = 0; mtimecmp = MTIMECMP_RESET; msip = 0.
  - Both synchroniser flops = 0; ack = 0; rdata = 0; mip_hw = 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick = (prescaler == TICK_DIV-1); with TICK_DIV=1, tick is asserted every cycle.
- mtime:
  - Increments by 1 on tick and wraps from 2^64-1 to 0.
  - The increment is a single 64-bit add, so a carry into the high word lands in the same cycle.
- Bus timing:
  - The access is captured on the req cycle; ack = 1 exactly one cycle later.
  - Throughput is one access per cycle: req may be asserted every cycle, giving ack every cycle.
  - There is no backpressure.
- Reads:
  - rdata reflects register values at the req cycle, before that cycle's increment or write.
  - Addr 0 returns {31'b0, msip}.
  - Unmapped addresses return 0 and are acked normally.
- Writes:
  - Take effect at the end of the req cycle, so new values are visible to a read issued on the next cycle.
  - Addr 0 updates msip from wdata[0]; wdata[31:1] are ignored.
  - mtimecmp halves are independently writable.
  - Writes to unmapped addresses are ignored and acked.
- mtime write vs tick: a write to either mtime half suppresses that cycle's increment entirely.
  - The written half takes wdata; the other half holds its value.
  - The prescaler keeps counting.
- mtip:
  - Registered: mip_hw.mtip = (mtime >= mtimecmp), unsigned 64-bit compare, evaluated on current register values.
  - Latency is one cycle after the compare condition becomes true or false.
  - Writing mtimecmp above mtime clears mtip one cycle after the write takes effect.
- msip: mip_hw.msip is a direct copy of the msip register, so the same cycle after the write.
- meip: two-flop synchroniser on ext_irq_async, giving 2-3 cycles of latency. It is level-sensitive; no latching and no clear.
- Reset mid-operation: all state returns immediately to reset values. Any in-flight ack is dropped (ack = 0) and no write completes.

Decomposition:
- csr_types package:
  - Add timer register offset constants MSIP_OFFSET, MTIMECMP_LO_OFFSET, MTIMECMP_HI_OFFSET, MTIME_LO_OFFSET, MTIME_HI_OFFSET.
  - mip_hw is declared as the existing mip_t.
- One sub-module: irq_synchronizer (2-flop, asynchronous active-low reset, parameterised width).
- Prescaler, counter, compare and bus logic stay in the top module.

Test Plan:
- Reset then idle 10 cycles, TICK_DIV=1 -> read addr 4 returns 10 (±0 relative to the req cycle count); mip_hw = 0; read addr 2/3 returns FFFF_FFFF.
- Write mtimecmp_hi=0, mtimecmp_lo=20 -> mtip rises exactly one cycle after mtime reaches 20. Then write mtimecmp_lo=FFFF_FFFF -> mtip falls one cycle after that write.
- Write mtime_hi=0, mtime_lo=FFFF_FFFE, then idle 3 cycles -> read hi=1, lo=1 (carry crosses the half boundary with no glitch read).
- TICK_DIV=4: write mtime_lo on a tick cycle -> that value is held, the next increment comes 4 cycles later; back-to-back reads every cycle give ack every cycle.
- Write addr 0 with 0xFFFF_FFFF -> msip = 1 (bit 3 of mip_hw) and read addr 0 = 1. Pulse ext_irq_async -> mip_hw bit 11 follows after 2-3 cycles. Unmapped addr 7 read = 0, acked.
- Assert rst while a req is pending -> ack is 0 the next cycle, mtime = 0, mtimecmp is restored to all ones, mip_hw = 0.
